// File: rtl/score_overlay_pkg.sv
// Shared definitions for the score overlay: sprite geometry, BCD nibble type,
// the double-dabble FSM state encoding and a small power-of-ten helper.
package score_overlay_pkg;

  localparam int unsigned DIGIT_W    = 25;
  localparam int unsigned DIGIT_H    = 52;
  localparam int unsigned DIGIT_GAP  = 4;
  localparam int unsigned SLOT_PITCH = DIGIT_W + DIGIT_GAP;

  typedef logic [3:0] bcd_nibble_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StHold
  } dabble_state_t;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift the
// concatenation {bcd, work} left by one bit.
// Ports:
//   bcd_in   - current BCD accumulator (NDIGITS nibbles)
//   work_in  - remaining binary bits, MSB shifts into the BCD LSB
//   bcd_out  - accumulator after adjust + shift
//   work_out - binary work register after shift
module bcd_dabble_step
  import score_overlay_pkg::*;
#(
  parameter int unsigned BIN_W   = 10,
  parameter int unsigned NDIGITS = 3
) (
  input  logic [4*NDIGITS-1:0] bcd_in,
  input  logic [BIN_W-1:0]     work_in,
  output logic [4*NDIGITS-1:0] bcd_out,
  output logic [BIN_W-1:0]     work_out
);

  logic [4*NDIGITS-1:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd_in;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      bcd_nibble_t nib;
      nib = bcd_in[4*i +: 4];
      if (nib >= 4'd5) bcd_adj[4*i +: 4] = nib + 4'd3;
    end
    {bcd_out, work_out} = {bcd_adj[4*NDIGITS-2:0], work_in, 1'b0};
  end

endmodule

// File: rtl/score_digit_source.sv
// Score digit source for the overlay sprite stage. Converts a binary score to
// BCD with a sequential double-dabble FSM, commits the result to the display
// register on a vsync rising edge, and presents per-pixel slot information.
// Ports:
//   pixel_clk      - pixel clock, all state on rising edge
//   reset          - asynchronous active-high reset
//   score          - binary score, sampled with score_valid
//   score_valid    - one-cycle conversion request
//   vsync          - raw vertical sync; rising edge commits a finished result
//   hcount         - current pixel column
//   busy           - conversion running or waiting to commit
//   display_update - one-cycle pulse on the commit edge
//   digit_x        - x origin of the slot under hcount (registered)
//   digit_val      - BCD value of that slot (registered)
//   digit_blank    - suppress drawing: leading zero or outside all slots
module score_digit_source
  import score_overlay_pkg::*;
#(
  parameter int unsigned BIN_W   = 10,
  parameter int unsigned NDIGITS = 3,
  parameter int unsigned WIDTH   = DIGIT_W,
  parameter int unsigned GAP     = DIGIT_GAP,
  parameter logic [10:0] X0      = 11'd40
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] score,
  input  logic             score_valid,
  input  logic             vsync,
  input  logic [10:0]      hcount,
  output logic             busy,
  output logic             display_update,
  output logic [10:0]      digit_x,
  output logic [3:0]       digit_val,
  output logic             digit_blank
);

  localparam int unsigned BCD_W = 4 * NDIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned SAT   = pow10(NDIGITS) - 1;
  localparam int unsigned PITCH = WIDTH + GAP;
  localparam logic [BIN_W-1:0] SAT_BIN = BIN_W'(SAT);

  dabble_state_t     state_q;
  logic [BIN_W-1:0]  work_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIN_W-1:0]  pend_q;
  logic              pend_valid_q;
  logic [BCD_W-1:0]  disp_q;
  logic              vsync_d_q;

  logic [BIN_W-1:0]  score_sat;
  logic [BCD_W-1:0]  bcd_step;
  logic [BIN_W-1:0]  work_step;
  logic              vsync_rise;
  logic              commit;

  always_comb begin
    score_sat = score;
    if (32'(score) > SAT) score_sat = SAT_BIN;
  end

  assign vsync_rise = vsync & ~vsync_d_q;
  assign commit     = (state_q == StHold) & vsync_rise;

  bcd_dabble_step #(
    .BIN_W   (BIN_W),
    .NDIGITS (NDIGITS)
  ) u_step (
    .bcd_in   (bcd_q),
    .work_in  (work_q),
    .bcd_out  (bcd_step),
    .work_out (work_step)
  );

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      work_q         <= '0;
      bcd_q          <= '0;
      cnt_q          <= '0;
      pend_q         <= '0;
      pend_valid_q   <= 1'b0;
      disp_q         <= '0;
      vsync_d_q      <= 1'b0;
      busy           <= 1'b0;
      display_update <= 1'b0;
    end else begin
      vsync_d_q      <= vsync;
      display_update <= 1'b0;

      // Requests arriving mid-conversion park in a single slot, latest wins.
      if (score_valid && (state_q != StIdle) && !commit) begin
        pend_q       <= score_sat;
        pend_valid_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (score_valid) begin
            work_q  <= score_sat;
            state_q <= StLoad;
            busy    <= 1'b1;
          end
        end
        StLoad: begin
          bcd_q   <= '0;
          cnt_q   <= CNT_W'(BIN_W);
          state_q <= StShift;
        end
        StShift: begin
          bcd_q  <= bcd_step;
          work_q <= work_step;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= StHold;
        end
        StHold: begin
          if (vsync_rise) begin
            disp_q         <= bcd_q;
            display_update <= 1'b1;
            // A strobe on the commit cycle is newer than anything pending.
            if (score_valid) begin
              work_q       <= score_sat;
              pend_valid_q <= 1'b0;
              state_q      <= StLoad;
            end else if (pend_valid_q) begin
              work_q       <= pend_q;
              pend_valid_q <= 1'b0;
              state_q      <= StLoad;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Slot decode; slot 0 holds the most-significant digit.
  logic [10:0] x_d;
  logic [3:0]  val_d;
  logic        blank_d;
  logic        lead_zero;
  logic [10:0] lo;
  logic [3:0]  nib;

  always_comb begin
    x_d       = X0;
    val_d     = 4'd0;
    blank_d   = 1'b1;
    lead_zero = 1'b1;
    lo        = X0;
    nib       = 4'd0;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      nib       = disp_q[4*(int'(NDIGITS)-1-i) +: 4];
      lead_zero = lead_zero & (nib == 4'd0);
      lo        = X0 + 11'(i * int'(PITCH));
      if ((hcount >= lo) && (hcount < lo + 11'(WIDTH))) begin
        x_d     = lo;
        val_d   = nib;
        blank_d = lead_zero && (i < int'(NDIGITS) - 1);
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      digit_x     <= X0;
      digit_val   <= 4'd0;
      digit_blank <= 1'b0;
    end else begin
      digit_x     <= x_d;
      digit_val   <= val_d;
      digit_blank <= blank_d;
    end
  end

endmodule

// File: tb/tb_score_digit_source.sv
module tb_score_digit_source;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  score;
  logic        score_valid;
  logic        vsync;
  logic [10:0] hcount;
  logic        busy;
  logic        display_update;
  logic [10:0] digit_x;
  logic [3:0]  digit_val;
  logic        digit_blank;

  int n_checks  = 0;
  int n_fail    = 0;
  int upd_count = 0;

  score_digit_source dut (
    .pixel_clk      (clk),
    .reset          (reset),
    .score          (score),
    .score_valid    (score_valid),
    .vsync          (vsync),
    .hcount         (hcount),
    .busy           (busy),
    .display_update (display_update),
    .digit_x        (digit_x),
    .digit_val      (digit_val),
    .digit_blank    (digit_blank)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (display_update === 1'b1) upd_count <= upd_count + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_slot(input logic [10:0] h, output logic [10:0] x, output logic [3:0] v,
                           output logic b);
    hcount = h;
    @(negedge clk);
    x = digit_x;
    v = digit_val;
    b = digit_blank;
  endtask

  task automatic strobe(input logic [9:0] s);
    score       = s;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
  endtask

  task automatic vsync_pulse;
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(1);
  endtask

  task automatic test_reset;
    reset = 1'b1; score = '0; score_valid = 1'b0; vsync = 1'b0; hcount = 11'd0;
    tick(3);
    n_checks++;
    if ({busy, display_update, digit_x, digit_val, digit_blank} !== {1'b0, 1'b0, 11'd40, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got busy=%0b upd=%0b x=%0d val=%0d blank=%0b, need 0 0 40 0 0",
               busy, display_update, digit_x, digit_val, digit_blank);
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_idle_sweep;
    logic [10:0] x, ex;
    logic [3:0] v;
    logic b, eb;
    for (int h = 0; h <= 200; h++) begin
      read_slot(11'(h), x, v, b);
      ex = 11'd40; eb = 1'b1;
      if (h >= 40 && h < 65) begin ex = 11'd40; eb = 1'b1; end
      else if (h >= 69 && h < 94) begin ex = 11'd69; eb = 1'b1; end
      else if (h >= 98 && h < 123) begin ex = 11'd98; eb = 1'b0; end
      n_checks++;
      if ({x, v, b} !== {ex, 4'd0, eb}) begin
        n_fail++;
        $display("FAIL idle_sweep h=%0d: got x=%0d val=%0d blank=%0b, need x=%0d val=0 blank=%0b",
                 h, x, v, b, ex, eb);
      end
    end
  endtask

  task automatic test_convert_437;
    logic [10:0] x;
    logic [3:0] v;
    logic b;
    int base;
    logic [3:0] ev[3] = '{4'd4, 4'd3, 4'd7};
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_before: got %0b need 0", busy); end
    strobe(10'd437);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_strobe: got %0b need 1", busy); end
    tick(20);
    base = upd_count;
    vsync = 1'b1;
    @(negedge clk);
    n_checks++;
    if (display_update !== 1'b1) begin
      n_fail++; $display("FAIL update_on_edge: got %0b need 1", display_update);
    end
    @(negedge clk);
    n_checks++;
    if (display_update !== 1'b0) begin
      n_fail++; $display("FAIL update_one_cycle: got %0b need 0", display_update);
    end
    vsync = 1'b0;
    tick(2);
    n_checks++;
    if (upd_count - base !== 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL commit_437: got pulses=%0d busy=%0b need 1 0", upd_count - base, busy);
    end
    for (int i = 0; i < 3; i++) begin
      read_slot(11'(40 + 29 * i + 3), x, v, b);
      n_checks++;
      if ({x, v, b} !== {11'(40 + 29 * i), ev[i], 1'b0}) begin
        n_fail++;
        $display("FAIL slot437_%0d: got x=%0d val=%0d blank=%0b, need x=%0d val=%0d blank=0",
                 i, x, v, b, 40 + 29 * i, ev[i]);
      end
    end
  endtask

  task automatic test_saturate_and_small;
    logic [10:0] x;
    logic [3:0] v;
    logic b;
    strobe(10'd1023);
    tick(20);
    vsync_pulse();
    for (int i = 0; i < 3; i++) begin
      read_slot(11'(40 + 29 * i + 24), x, v, b);
      n_checks++;
      if ({v, b} !== {4'd9, 1'b0}) begin
        n_fail++; $display("FAIL saturate_%0d: got val=%0d blank=%0b need 9 0", i, v, b);
      end
    end
    strobe(10'd5);
    tick(20);
    vsync_pulse();
    read_slot(11'd40, x, v, b);
    n_checks++;
    if (b !== 1'b1) begin n_fail++; $display("FAIL small_slot0: got blank=%0b need 1", b); end
    read_slot(11'd93, x, v, b);
    n_checks++;
    if (b !== 1'b1) begin n_fail++; $display("FAIL small_slot1: got blank=%0b need 1", b); end
    read_slot(11'd122, x, v, b);
    n_checks++;
    if ({x, v, b} !== {11'd98, 4'd5, 1'b0}) begin
      n_fail++; $display("FAIL small_slot2: got x=%0d val=%0d blank=%0b need 98 5 0", x, v, b);
    end
    read_slot(11'd66, x, v, b);
    n_checks++;
    if ({x, b} !== {11'd40, 1'b1}) begin
      n_fail++; $display("FAIL gap: got x=%0d blank=%0b need 40 1", x, b);
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] x;
    logic [3:0] v;
    logic b;
    int base;
    base = upd_count;
    strobe(10'd12);
    tick(3);
    strobe(10'd88);
    tick(20);
    vsync_pulse();
    read_slot(11'd40, x, v, b);
    n_checks++;
    if (b !== 1'b1) begin n_fail++; $display("FAIL b2b_first_s0: got blank=%0b need 1", b); end
    read_slot(11'd70, x, v, b);
    n_checks++;
    if ({v, b} !== {4'd1, 1'b0}) begin
      n_fail++; $display("FAIL b2b_first_s1: got val=%0d blank=%0b need 1 0", v, b);
    end
    read_slot(11'd100, x, v, b);
    n_checks++;
    if ({v, b, busy} !== {4'd2, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL b2b_first_s2: got val=%0d blank=%0b busy=%0b need 2 0 1", v, b, busy);
    end
    tick(20);
    vsync_pulse();
    read_slot(11'd70, x, v, b);
    n_checks++;
    if ({v, b} !== {4'd8, 1'b0}) begin
      n_fail++; $display("FAIL b2b_second_s1: got val=%0d blank=%0b need 8 0", v, b);
    end
    read_slot(11'd100, x, v, b);
    n_checks++;
    if ({v, busy} !== {4'd8, 1'b0}) begin
      n_fail++; $display("FAIL b2b_second_s2: got val=%0d busy=%0b need 8 0", v, busy);
    end
    n_checks++;
    if (upd_count - base !== 2) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d need 2", upd_count - base);
    end
  endtask

  task automatic test_vsync_high;
    logic [10:0] x;
    logic [3:0] v;
    logic b;
    int base;
    vsync = 1'b1;
    tick(3);
    base = upd_count;
    strobe(10'd256);
    tick(25);
    read_slot(11'd100, x, v, b);
    n_checks++;
    if ({upd_count - base, busy, v} !== {32'd0, 1'b1, 4'd8}) begin
      n_fail++;
      $display("FAIL vsync_held: got pulses=%0d busy=%0b val=%0d need 0 1 8", upd_count - base, busy, v);
    end
    vsync = 1'b0;
    tick(1);
    vsync_pulse();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] e;
      e = (i == 0) ? 4'd2 : (i == 1) ? 4'd5 : 4'd6;
      read_slot(11'(40 + 29 * i + 10), x, v, b);
      n_checks++;
      if ({v, b} !== {e, 1'b0}) begin
        n_fail++; $display("FAIL vsync_commit_%0d: got val=%0d blank=%0b need %0d 0", i, v, b, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] x;
    logic [3:0] v;
    logic b;
    int base;
    strobe(10'd300);
    tick(4);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, display_update, digit_x, digit_val, digit_blank} !== {1'b0, 1'b0, 11'd40, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%0b upd=%0b x=%0d val=%0d blank=%0b, need 0 0 40 0 0",
               busy, display_update, digit_x, digit_val, digit_blank);
    end
    tick(2);
    reset = 1'b0;
    tick(20);
    base = upd_count;
    vsync_pulse();
    tick(1);
    n_checks++;
    if ({upd_count - base, busy} !== {32'd0, 1'b0}) begin
      n_fail++; $display("FAIL post_reset_vsync: got pulses=%0d busy=%0b need 0 0", upd_count - base, busy);
    end
    read_slot(11'd98, x, v, b);
    n_checks++;
    if ({x, v, b} !== {11'd98, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL post_reset_s2: got x=%0d val=%0d blank=%0b need 98 0 0", x, v, b);
    end
    read_slot(11'd45, x, v, b);
    n_checks++;
    if ({v, b} !== {4'd0, 1'b1}) begin
      n_fail++; $display("FAIL post_reset_s0: got val=%0d blank=%0b need 0 1", v, b);
    end
  endtask

  initial begin
    test_reset();
    test_idle_sweep();
    test_convert_437();
    test_saturate_and_small();
    test_back_to_back();
    test_vsync_high();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_digit_source.md
Name: score_digit_source

Overview:
- Upstream feeder for the digit sprite stage in the score overlay.
- Converts a binary drum-hit score to packed BCD using a sequential shift-add-3 (double-dabble) FSM.
- Commits the converted value to the display register only on a vsync rising edge, so a digit never tears mid-frame.
- Every pixel clock it presents the x origin, digit value and blank flag for the digit slot under the current hcount. The sprite stage uses these for its overlap test and ROM addressing.

Parameters:
- BIN_W, 10, width of the binary score input.
- NDIGITS, 3, number of decimal digits shown; saturation value is 10^NDIGITS-1.
- WIDTH, 25, digit sprite width in pixels; must match the sprite stage.
- GAP, 4, horizontal pixels between adjacent digit slots.
- X0, 11'd40, x origin of the most-significant digit slot.

Ports:
- pixel_clk  input  1  pixel clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- score  input  BIN_W  binary score; sampled when score_valid=1.
- score_valid  input  1  one-cycle strobe requesting conversion.
- vsync  input  1  raw vertical sync, active-high; its rising edge is the commit point.
- hcount  input  11  current pixel column.
- busy  output  1  high while a conversion is running or waiting to commit.
- display_update  output  1  one-cycle pulse on the commit edge.
- digit_x  output  11  registered x origin of the slot containing hcount.
- digit_val  output  4  registered BCD value of that slot.
- digit_blank  output  1  registered; 1 = suppress drawing (leading zero or outside all slots).

Behaviour:
- Reset values: busy=0, display_update=0, digit_x=X0, digit_val=0, digit_blank=0 (slot 0 shows "0"), display register=all zeros, FSM=IDLE, pending flag=0, vsync_d=0.
- FSM states: IDLE, LOAD, SHIFT, HOLD.
- IDLE: on score_valid, capture score into the work register and go to LOAD. If score > 10^NDIGITS-1, capture 10^NDIGITS-1 instead (1023 -> 999).
- LOAD: clear the BCD accumulator, load bit counter = BIN_W, go to SHIFT.
- SHIFT: one bit per cycle. Add 3 to every BCD nibble >= 5, then shift {bcd, work} left by 1 and decrement the counter. At the last bit, go to HOLD.
- HOLD: wait for the vsync rising edge (vsync=1 while vsync_d=0). On that edge:
  - copy the BCD result into the display register;
  - pulse display_update for exactly one cycle;
  - go to IDLE, or to LOAD if a pending request exists.
- Latency: score_valid sampled at edge k; result ready in HOLD at edge k+BIN_W+2; commit at the first vsync rising edge at or after that edge.
- busy: 1 in LOAD, SHIFT and HOLD; 0 in IDLE.
- score_valid while busy: overwrite a single pending slot (latest value wins) and set the pending flag. On leaving HOLD, start the pending value; never drop it.
- score_valid in the same cycle as the commit: it becomes the next conversion directly.
- vsync high when HOLD is entered with no new rising edge: wait for the next edge.
- Slot decode:
  - slot i spans [X0 + i*(WIDTH+GAP), X0 + i*(WIDTH+GAP) + WIDTH).
  - digit_x, digit_val and digit_blank are registered one cycle after hcount.
  - hcount outside all slots (including gaps): digit_blank=1, digit_x=X0.
- Leading-zero suppression: blank slot i when all digits of index <= i are zero and i < NDIGITS-1. The last digit is always shown.
- Arithmetic: slot bounds are 11-bit unsigned; no wrap is needed for defaults.
- Reset mid-conversion: abort, drop any pending request, restore reset values.

Decomposition:
- Shared package (score_overlay_pkg): DIGIT_W=25, DIGIT_H=52, SLOT_PITCH=WIDTH+GAP, BCD nibble typedef, FSM state enum.
- One natural sub-module: bcd_dabble_step. Combinational add-3 on all nibbles followed by the 1-bit shift, instantiated inside the SHIFT datapath.

Test Plan:
- Reset, then sweep hcount over 0..200 with no score -> digit_val=0 everywhere; slots 0,1 blank; slot 2 at x=98 (40+2*29) visible with value 0.
- score=437 strobe, vsync rising 20 cycles later -> busy high 1 cycle after strobe, display_update one pulse on the vsync edge; slots read 4,3,7 at x=40,69,98.
- score=1023 -> display 9,9,9 (saturated); score=5 -> slots 0,1 blank, slot 2 shows 5.
- Strobe 12 then 88 while busy, one vsync per conversion -> first commit shows 12, second shows 88; exactly two display_update pulses.
- vsync held high throughout conversion -> no commit until the next rising edge.
- Assert reset mid-SHIFT after strobing 300 -> outputs return to reset values, busy=0, no display_update; a later vsync commits nothing.
